ahb_wait_slave: RTL and testbench
=================================

Name: ahb_wait_slave

Overview:
- AHB-Lite memory slave selected by one `hsel_n` line of `ahb_decoder`.
- Drives `hrdata`, `hreadyout` and `hresp` into one input set of `ahb_multiplexer`.
- Adds a word-addressed RAM, a parameterised wait-state count, byte/halfword writes and the two-cycle ERROR response.
- Drop-in replacement for any slave slot in `ahb_top`.

Parameters:
- DEPTH, 256, number of 32-bit words; valid byte address range is 0 to DEPTH*4-1.
- WAIT_STATES, 0, `hreadyout`-low cycles inserted in every OKAY data phase (0..15).
- ADDR_W, 32, `haddr` width.

Ports:
- hclk  in  1  bus clock. One clock, all logic on rising edge.
- hreset  in  1  reset, asynchronous, active-high.
- hsel  in  1  slave select from the decoder.
- haddr  in  ADDR_W  address-phase byte address.
- hwrite  in  1  1 = write, 0 = read.
- hsize  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
- hburst  in  3  burst type; accepted, not used.
- hprot  in  4  protection; accepted, not used.
- htrans  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- hmastlock  in  1  locked transfer; accepted, not used.
- hready  in  1  bus-wide ready (muxed `hreadyout`).
- hwdata  in  32  write data, valid in the data phase.
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.

Behaviour:
- Reset (async, any state): state = IDLE, `hreadyout` = 1, `hresp` = 0, `hrdata` = 0. Captured address-phase registers are cleared. Any pending write is dropped. RAM contents are not reset.
- Address-phase accept condition: `hsel & hready & htrans[1]`. On accept, register `haddr`, `hwrite`, `hsize`.
- A transfer is illegal if any of the following holds; illegal transfers are classified at accept:
  - `haddr >= DEPTH*4`
  - `hsize > 2`
  - `hsize == 1` with `haddr[0] == 1`
  - `hsize == 2` with `haddr[1:0] != 0`
- IDLE/BUSY transfers, or `hsel = 0`, while `hready = 1`: no access. The next cycle is zero-wait OKAY (`hreadyout` = 1, `hresp` = 0).
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE, legal accept: go to WAIT if WAIT_STATES > 0, else DATA.
  - IDLE, illegal accept: go to ERR1.
  - WAIT: `hreadyout` = 0, wait counter increments each cycle. After WAIT_STATES cycles go to DATA.
  - DATA: `hreadyout` = 1, `hresp` = 0. A write commits at the end of this cycle. A read drives `hrdata`. The next state follows the accept condition sampled in this same cycle (pipelined back-to-back: DATA to DATA, WAIT, ERR1 or IDLE).
  - ERR1: `hreadyout` = 0, `hresp` = 1; go to ERR2.
  - ERR2: `hreadyout` = 1, `hresp` = 1. The next state follows the accept condition sampled in this cycle, exactly as in DATA.
- The slave never accepts a new address phase while its own `hreadyout` = 0, because `hready` is low then.
- Write commit:
  - Byte strobes are derived from the registered `hsize` and `haddr[1:0]` (little-endian).
  - Only strobed lanes of `mem[addr >> 2]` take `hwdata`; other lanes keep their contents.
  - No write occurs on error or on reset.
- Read data:
  - `hrdata` = `mem[registered addr >> 2]`, full word, in DATA for reads. It is 0 in all other states.
  - A read whose address phase coincides with the DATA cycle of a write to the same word returns the newly written lanes. This holds because the commit happens at that edge and the read samples in its own data phase.
- Wait counter width is 4 bits. It is cleared on entry to WAIT and never wraps, because it is bounded by WAIT_STATES.

Decomposition:
- Package `ahb_pkg`:
  - HTRANS codes: IDLE, BUSY, NONSEQ, SEQ.
  - HSIZE codes: BYTE, HALF, WORD.
  - HRESP codes: OKAY, ERROR.
  - FSM state enum.
- One sub-module, `ahb_byte_strobe`: combinational; inputs `hsize` and `addr[1:0]`, output 4-bit lane enable. It is shared with future slaves.

Test Plan:
- WAIT_STATES = 0. Write word 0xDEADBEEF to 0x10, then read 0x10 back-to-back. Required: write data phase `hreadyout` = 1. The read data phase, one cycle later, returns `hrdata` = 0xDEADBEEF with `hresp` = 0.
- WAIT_STATES = 2. Read 0x10. Required: `hreadyout` = 0 for exactly 2 cycles, then 1 with `hrdata` = 0xDEADBEEF.
- Write word 0x00000000 to 0x20, then byte write `hsize` = 0 to 0x21 with `hwdata` = 0x0000AB00, then word read 0x20. Required: read returns 0x0000AB00.
- DEPTH = 256. NONSEQ read to 0x400, and separately a word access to 0x02. Required: ERR1 (`hresp` = 1, `hreadyout` = 0), then ERR2 (`hresp` = 1, `hreadyout` = 1). RAM is unchanged; a check read of 0x00 confirms its prior value.
- `htrans` = BUSY with `hsel` = 1, and separately `hsel` = 0 with NONSEQ. Required: `hreadyout` stays 1, `hresp` = 0, no RAM change.
- WAIT_STATES = 3. Assert `hreset` in the second wait cycle of a write of 0x12345678 to 0x30 (0x30 previously holds 0xCAFEF00D). Required: outputs return to reset values immediately. A later read of 0x30 returns 0xCAFEF00D.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the wait-state slave FSM state type.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_e;

    localparam int unsigned WCNT_W = 4;

endpackage

// File: rtl/ahb_byte_strobe.sv
// Little-endian byte-lane enables for an AHB transfer of a given size and offset.
module ahb_byte_strobe
    import ahb_pkg::*;
(
    input  logic [2:0] hsize_i,
    input  logic [1:0] addr_i,
    output logic [3:0] strb_o
);

    // Lane decode; unsupported sizes enable no lanes
    always_comb begin
        strb_o = 4'b0000;
        case (hsize_i)
            HSIZE_BYTE: strb_o = 4'b0001 << addr_i;
            HSIZE_HALF: strb_o = addr_i[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb_o = 4'b1111;
            default:    strb_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_wait_slave.sv
// AHB-Lite RAM slave with configurable wait states and two-cycle ERROR response.
module ahb_wait_slave
    import ahb_pkg::*;
#(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              hsel,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [3:0]        hprot,
    input  logic [1:0]        htrans,
    input  logic              hmastlock,
    input  logic              hready,
    input  logic [31:0]       hwdata,
    output logic              hreadyout,
    output logic              hresp,
    output logic [31:0]       hrdata
);

    localparam int unsigned       IDX_W      = $clog2(DEPTH);
    localparam int unsigned       AQ_W       = IDX_W + 2;
    localparam logic [ADDR_W:0]   ADDR_LIMIT = (ADDR_W + 1)'(DEPTH) << 2;
    localparam logic [WCNT_W-1:0] WAIT_LAST  =
        (WAIT_STATES == 0) ? '0 : WCNT_W'(WAIT_STATES - 1);

    state_e            state_q, state_d;
    logic [AQ_W-1:0]   addr_q,  addr_d;
    logic              write_q, write_d;
    logic [2:0]        size_q,  size_d;
    logic [WCNT_W-1:0] wcnt_q,  wcnt_d;

    logic              accept;
    logic              illegal;
    logic [3:0]        strb;
    logic [31:0]       mem [DEPTH];

    // Bus control signals this slave does not act on
    logic unused_ok;
    assign unused_ok = ^{hburst, hprot, hmastlock, htrans[0]};

    assign accept  = hsel & hready & htrans[1];
    assign illegal = ({1'b0, haddr} >= ADDR_LIMIT)
                   | (hsize > 3'd2)
                   | ((hsize == HSIZE_HALF) & haddr[0])
                   | ((hsize == HSIZE_WORD) & (haddr[1:0] != 2'b00));

    ahb_byte_strobe u_strobe (
        .hsize_i (size_q),
        .addr_i  (addr_q[1:0]),
        .strb_o  (strb)
    );

    // State and captured address-phase registers
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Next-state and response decode; IDLE, DATA and ERR2 all pipeline a new accept
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        write_d   = write_q;
        size_d    = size_q;
        wcnt_d    = wcnt_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (state_q == ST_ERR2) hresp = HRESP_ERROR;
                if (accept) begin
                    addr_d  = haddr[AQ_W-1:0];
                    write_d = hwrite;
                    size_d  = hsize;
                    wcnt_d  = '0;
                    if (illegal)              state_d = ST_ERR1;
                    else if (WAIT_STATES != 0) state_d = ST_WAIT;
                    else                       state_d = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                hreadyout = 1'b0;
                if (wcnt_q == WAIT_LAST) state_d = ST_DATA;
                else                     wcnt_d  = wcnt_q + 1'b1;
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Write commit at the end of the DATA cycle; strobed lanes only
    always_ff @(posedge hclk) begin
        if (state_q == ST_DATA && write_q) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (strb[i]) mem[addr_q[AQ_W-1:2]][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    assign hrdata = (state_q == ST_DATA && !write_q) ? mem[addr_q[AQ_W-1:2]] : '0;

endmodule

// File: tb/tb_ahb_wait_slave.sv
// Scoreboard bench: three slave instances (0, 2 and 3 wait states) each on its own bus.
module tb_ahb_wait_slave;

    typedef struct {
        int          waits;
        bit          resp;
        logic [31:0] rdata;
    } exp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    logic hclk        = 1'b0;

    always #5 hclk = ~hclk;

    task automatic chk(input string name, input int cfgid,
                       input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s cfg%0d: got %h expected %h at %0t", name, cfgid, act, want, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : cfg
        localparam int WS = (g == 0) ? 0 : ((g == 1) ? 2 : 3);

        logic        rst, hsel, hwrite, hreadyout, hresp;
        logic [31:0] haddr, hwdata, hrdata;
        logic [2:0]  hsize;
        logic [1:0]  htrans;
        logic [31:0] model [256];
        exp_t        q[$];
        bit          done = 1'b0;

        ahb_wait_slave #(.DEPTH(256), .WAIT_STATES(WS), .ADDR_W(32)) dut (
            .hclk      (hclk),
            .hreset    (rst),
            .hsel      (hsel),
            .haddr     (haddr),
            .hwrite    (hwrite),
            .hsize     (hsize),
            .hburst    (3'b000),
            .hprot     (4'b0011),
            .htrans    (htrans),
            .hmastlock (1'b0),
            .hready    (hreadyout),
            .hwdata    (hwdata),
            .hreadyout (hreadyout),
            .hresp     (hresp),
            .hrdata    (hrdata)
        );

        // Called at posedge+1; drives an address phase, waits for it to be taken,
        // predicts the response and presents the write data for its data phase.
        task automatic issue(input bit sel, input logic [1:0] tr, input logic [31:0] a,
                             input bit wr, input logic [2:0] sz, input logic [31:0] wd);
            exp_t        e;
            int          n;
            int unsigned nb, b;
            bit          bad;
            hsel = sel; htrans = tr; haddr = a; hwrite = wr; hsize = sz;
            n = 0;
            @(negedge hclk);
            while (hreadyout !== 1'b1 && n < 40) begin
                @(negedge hclk);
                n++;
            end
            if (hreadyout !== 1'b1) chk("accept_timeout", g, 32'd0, 32'd1);
            @(posedge hclk);
            #1;
            e.waits = 0; e.resp = 1'b0; e.rdata = '0;
            if (sel && tr[1]) begin
                nb  = (sz <= 3'd2) ? (1 << sz) : 1;
                bad = (a >= 32'd1024) || (sz > 3'd2) || ((a % nb) != 0);
                if (bad) begin
                    e.waits = 1;
                    e.resp  = 1'b1;
                end else begin
                    e.waits = WS;
                    if (wr) begin
                        for (int unsigned k = 0; k < nb; k++) begin
                            b = (a % 4) + k;
                            model[a / 4][8*b +: 8] = wd[8*b +: 8];
                        end
                    end else begin
                        e.rdata = model[a / 4];
                    end
                end
            end
            q.push_back(e);
            hwdata = wd;
            hsel   = 1'b0;
            htrans = 2'b00;
        endtask

        // Wait for every outstanding response, then realign to posedge+1
        task automatic drain();
            int n;
            n = 0;
            while (q.size() != 0 && n < 100) begin
                @(negedge hclk);
                n++;
            end
            if (q.size() != 0) begin
                chk("drain_timeout", g, q.size(), 32'd0);
                q.delete();
            end
            @(posedge hclk);
            #1;
        endtask

        // Stimulus
        initial begin : drv
            logic [31:0] a, wd;
            logic [2:0]  sz;
            logic [1:0]  tr;
            bit          sel, wr;
            int          n;
            rst = 1'b1; hsel = 1'b0; hwrite = 1'b0; hsize = 3'd0;
            htrans = 2'b00; haddr = '0; hwdata = '0;
            #1;
            chk("reset_hreadyout", g, hreadyout, 32'd1);
            chk("reset_hresp", g, hresp, 32'd0);
            chk("reset_hrdata", g, hrdata, 32'd0);
            repeat (3) @(negedge hclk);
            rst = 1'b0;
            @(posedge hclk);
            #1;

            for (int i = 0; i < 256; i++) issue(1'b1, 2'b10, i * 4, 1'b1, 3'd2, $urandom);

            // Back-to-back write then read of the same word
            issue(1'b1, 2'b10, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF);
            issue(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0);
            // Byte lane write merges into an existing word
            issue(1'b1, 2'b10, 32'h20, 1'b1, 3'd2, 32'h00000000);
            issue(1'b1, 2'b11, 32'h21, 1'b1, 3'd0, 32'h0000AB00);
            issue(1'b1, 2'b10, 32'h20, 1'b0, 3'd2, 32'h0);
            // Out-of-range and misaligned transfers, then confirm word 0 untouched
            issue(1'b1, 2'b10, 32'h400, 1'b0, 3'd2, 32'h0);
            issue(1'b1, 2'b10, 32'h02, 1'b1, 3'd2, 32'h5A5A5A5A);
            issue(1'b1, 2'b10, 32'h00, 1'b0, 3'd2, 32'h0);
            // BUSY and deselected NONSEQ are no-access cycles
            issue(1'b1, 2'b01, 32'h10, 1'b1, 3'd2, 32'h11111111);
            issue(1'b0, 2'b10, 32'h10, 1'b1, 3'd2, 32'h22222222);
            issue(1'b1, 2'b10, 32'h10, 1'b0, 3'd2, 32'h0);

            // Reset during the write's wait phase drops the write
            issue(1'b1, 2'b10, 32'h30, 1'b1, 3'd2, 32'hCAFEF00D);
            drain();
            hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
            n = 0;
            @(negedge hclk);
            while (hreadyout !== 1'b1 && n < 40) begin
                @(negedge hclk);
                n++;
            end
            @(posedge hclk);
            #1;
            hwdata = 32'h12345678; hsel = 1'b0; htrans = 2'b00;
            repeat ((WS >= 2) ? 1 : 0) begin
                @(posedge hclk);
                #1;
            end
            rst = 1'b1;
            #1;
            chk("midreset_hreadyout", g, hreadyout, 32'd1);
            chk("midreset_hresp", g, hresp, 32'd0);
            chk("midreset_hrdata", g, hrdata, 32'd0);
            repeat (2) @(negedge hclk);
            rst = 1'b0;
            @(posedge hclk);
            #1;
            issue(1'b1, 2'b10, 32'h30, 1'b0, 3'd2, 32'h0);

            // Randomised traffic, mostly legal with some illegal sizes and addresses
            repeat (150) begin
                sel = ($urandom_range(0, 7) != 0);
                tr  = 2'($urandom_range(0, 3));
                sz  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7))
                                                   : 3'($urandom_range(0, 2));
                if ($urandom_range(0, 9) == 0) begin
                    a = $urandom_range(0, 2047);
                end else begin
                    a = $urandom_range(0, 1023);
                    if (sz <= 3'd2) a = a - (a % (1 << sz));
                end
                wr = ($urandom_range(0, 1) == 1);
                wd = $urandom;
                issue(sel, tr, a, wr, sz, wd);
            end
            drain();
            done = 1'b1;
        end

        // Monitor: count stall cycles of the oldest response, compare when ready
        initial begin : mon
            exp_t e;
            int   low;
            low = 0;
            forever begin
                @(negedge hclk);
                if (rst === 1'b1 || q.size() == 0) begin
                    low = 0;
                end else begin
                    e = q[0];
                    if (hreadyout !== 1'b1) begin
                        chk("stall_hresp", g, hresp, e.resp);
                        low++;
                        if (low > 40) begin
                            chk("stall_bound", g, low, e.waits);
                            void'(q.pop_front());
                            low = 0;
                        end
                    end else begin
                        void'(q.pop_front());
                        chk("wait_cycles", g, low, e.waits);
                        chk("hresp", g, hresp, e.resp);
                        chk("hrdata", g, hrdata, e.rdata);
                        low = 0;
                    end
                end
            end
        end
    end

    initial begin : summary
        int n;
        n = 0;
        while (!(cfg[0].done && cfg[1].done && cfg[2].done) && n < 20000) begin
            @(negedge hclk);
            n++;
        end
        if (!(cfg[0].done && cfg[1].done && cfg[2].done)) chk("global_timeout", -1, 32'd0, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
